// File: rtl/utils_top_pkg.sv
// Shared core-level types and constants: pipeline control states, opcodes, bubble encoding.
package utils_top;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // addi x0, x0, 0: the canonical no-op injected by pipeline kills
  localparam logic [XLEN-1:0] BUBBLE = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    MWAIT = 2'd2,
    HALT  = 2'd3
  } pipe_ctrl_st_t;

endpackage

// File: rtl/pipe_ctrl_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_ctrl_satcnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stage enables, kill strobes, halt latch and perf counters.
module pipe_ctrl
  import utils_top::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             intrlock_bubble,
  input  logic             ex_branch_flush,
  input  logic             dmem_busy,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exma_en,
  output logic             mawb_en,
  output logic             if_kill,
  output logic             id_kill,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_ctrl_st_t state;
  pipe_ctrl_st_t state_nxt;
  logic          en_all;
  logic          front_hold;
  logic          flush_acc;
  logic          stall_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Requests resolved by priority: halt > memory freeze > branch flush > interlock.
  // MWAIT needs no branch of its own: once dmem_busy drops it decodes exactly like RUN.
  always_comb begin
    state_nxt  = state;
    en_all     = 1'b0;
    front_hold = 1'b0;
    if_kill    = 1'b0;
    id_kill    = 1'b0;
    flush_acc  = 1'b0;
    if (rst) begin
      state_nxt = RUN;
    end else if (state == HALT) begin
      state_nxt = HALT;
    end else if (halt_req) begin
      state_nxt = HALT;
    end else if (dmem_busy) begin
      state_nxt = MWAIT;
    end else if (ex_branch_flush) begin
      en_all    = 1'b1;
      if_kill   = 1'b1;
      id_kill   = 1'b1;
      flush_acc = 1'b1;
      state_nxt = FLUSH;
    end else if (state == FLUSH) begin
      // one more fetch was already in flight from the wrong path
      en_all    = 1'b1;
      if_kill   = 1'b1;
      state_nxt = RUN;
    end else if (intrlock_bubble) begin
      en_all     = 1'b1;
      front_hold = 1'b1;
      id_kill    = 1'b1;
      state_nxt  = RUN;
    end else begin
      en_all    = 1'b1;
      state_nxt = RUN;
    end
  end

  assign pc_en     = en_all & ~front_hold;
  assign ifid_en   = en_all & ~front_hold;
  assign idex_en   = en_all;
  assign exma_en   = en_all;
  assign mawb_en   = en_all;
  assign halted    = (state == HALT) & ~rst;
  assign stall_inc = ~rst & (state != HALT) & ~pc_en;

  pipe_ctrl_satcnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_ctrl_satcnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush_acc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand sequences and randomized model comparison.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic intrlock_bubble = 1'b0;
  logic ex_branch_flush = 1'b0;
  logic dmem_busy = 1'b0;
  logic halt_req = 1'b0;

  logic pc_en, ifid_en, idex_en, exma_en, mawb_en, if_kill, id_kill, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic pc_en4, ifid_en4, idex_en4, exma_en4, mawb_en4, if_kill4, id_kill4, halted4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .intrlock_bubble(intrlock_bubble),
    .ex_branch_flush(ex_branch_flush), .dmem_busy(dmem_busy), .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exma_en(exma_en),
    .mawb_en(mawb_en), .if_kill(if_kill), .id_kill(id_kill), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .intrlock_bubble(intrlock_bubble),
    .ex_branch_flush(ex_branch_flush), .dmem_busy(dmem_busy), .halt_req(halt_req),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exma_en(exma_en4),
    .mawb_en(mawb_en4), .if_kill(if_kill4), .id_kill(id_kill4), .halted(halted4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // {pc, ifid, idex, exma, mawb, if_kill, id_kill}
  function automatic logic [6:0] outs();
    return {pc_en, ifid_en, idex_en, exma_en, mawb_en, if_kill, id_kill};
  endfunction

  function automatic logic [6:0] outs4();
    return {pc_en4, ifid_en4, idex_en4, exma_en4, mawb_en4, if_kill4, id_kill4};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pipe is either halted, just after an accepted flush, or neither.
  bit      m_valid = 1'b0;
  bit      m_halt = 1'b0;
  bit      m_post_flush = 1'b0;
  longint  m_stall = 0;
  longint  m_flush = 0;
  int      m_stall4 = 0;
  int      m_flush4 = 0;

  function automatic logic [6:0] model_outs(input bit r, input bit b, input bit f,
                                            input bit d, input bit h);
    if (r || m_halt || h || d) return 7'b00000_00;
    if (f)                     return 7'b11111_11;
    if (m_post_flush)          return 7'b11111_10;
    if (b)                     return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  task automatic model_step(input bit r, input bit b, input bit f, input bit d, input bit h);
    logic [6:0] o;
    o = model_outs(r, b, f, d, h);
    if (r) begin
      m_valid = 1'b1; m_halt = 1'b0; m_post_flush = 1'b0;
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
      return;
    end
    if (!m_halt && !o[6]) begin
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (!m_halt && !h && !d && f) begin
      if (m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_flush4 < 15) m_flush4++;
    end
    if (m_halt || h)      m_halt = 1'b1;
    else if (d)           m_post_flush = 1'b0;
    else                  m_post_flush = f;
  endtask

  // One clock: drive at negedge, compare before the rising edge, then advance the model.
  task automatic cycle(input bit r, input bit b, input bit f, input bit d, input bit h);
    @(negedge clk);
    rst = r; intrlock_bubble = b; ex_branch_flush = f; dmem_busy = d; halt_req = h;
    #1;
    chk("model_outs", 64'(outs()), 64'(model_outs(r, b, f, d, h)));
    chk("model_outs_w4", 64'(outs4()), 64'(model_outs(r, b, f, d, h)));
    chk("model_halted", 64'(halted), 64'(!r && m_halt));
    if (m_valid) begin
      chk("model_stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("model_flush_cnt", 64'(flush_cnt), 64'(m_flush));
      chk("model_stall_cnt_w4", 64'(stall_cnt4), 64'(m_stall4));
      chk("model_flush_cnt_w4", 64'(flush_cnt4), 64'(m_flush4));
    end
    @(posedge clk);
    model_step(r, b, f, d, h);
  endtask

  typedef struct {
    bit         r, b, f, d, h;
    logic [6:0] exp_out;
    bit         exp_halted;
    int         exp_stall;
    int         exp_flush;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit b, input bit f, input bit d, input bit h,
                     input logic [6:0] eo, input bit eh, input int es, input int ef);
    vec_t v;
    v.r = r; v.b = b; v.f = f; v.d = d; v.h = h;
    v.exp_out = eo; v.exp_halted = eh; v.exp_stall = es; v.exp_flush = ef;
    vecs.push_back(v);
  endtask

  initial begin
    // reset, idle, single interlock
    add(1, 0, 0, 0, 0, 7'b0000000, 0, -1, -1);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 7'b1111100, 0, 0, 0);
    add(0, 1, 0, 0, 0, 7'b0011101, 0, 0, 0);
    add(0, 0, 0, 0, 0, 7'b1111100, 0, 1, 0);
    // flush together with interlock, then the FLUSH shadow cycle
    add(0, 1, 1, 0, 0, 7'b1111111, 0, 1, 0);
    add(0, 0, 0, 0, 0, 7'b1111110, 0, 1, 1);
    add(0, 0, 0, 0, 0, 7'b1111100, 0, 1, 1);
    // memory freeze with a pending flush, accepted on release
    for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 7'b0000000, 0, 1 + i, 1);
    add(0, 0, 1, 0, 0, 7'b1111111, 0, 5, 1);
    add(0, 0, 0, 0, 0, 7'b1111110, 0, 5, 2);
    // freeze, halt while frozen, then halted
    add(0, 0, 0, 1, 0, 7'b0000000, 0, 5, 2);
    add(0, 0, 0, 1, 1, 7'b0000000, 0, 6, 2);
    add(0, 1, 1, 0, 0, 7'b0000000, 1, 7, 2);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r; intrlock_bubble = vecs[i].b; ex_branch_flush = vecs[i].f;
      dmem_busy = vecs[i].d; halt_req = vecs[i].h;
      #1;
      chk($sformatf("vec%0d_outs", i), 64'(outs()), 64'(vecs[i].exp_out));
      chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(vecs[i].exp_halted));
      if (vecs[i].exp_stall >= 0) begin
        chk($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(vecs[i].exp_stall));
        chk($sformatf("vec%0d_flush", i), 64'(flush_cnt), 64'(vecs[i].exp_flush));
      end
      @(posedge clk);
      model_step(vecs[i].r, vecs[i].b, vecs[i].f, vecs[i].d, vecs[i].h);
    end

    // HALT is sticky against every other input
    for (int i = 0; i < 22; i++) begin
      cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk); #1;
    chk("halt_sticky_halted", 64'(halted), 64'(1));
    chk("halt_sticky_stall", 64'(stall_cnt), 64'(7));
    chk("halt_sticky_flush", 64'(flush_cnt), 64'(2));

    // rst pulse out of HALT; normal outputs resume the following cycle
    cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0; intrlock_bubble = 0; ex_branch_flush = 0; dmem_busy = 0; halt_req = 0;
    #1;
    chk("post_rst_outs", 64'(outs()), 64'(7'b1111100));
    chk("post_rst_halted", 64'(halted), 64'(0));
    chk("post_rst_stall", 64'(stall_cnt), 64'(0));
    chk("post_rst_flush", 64'(flush_cnt), 64'(0));
    @(posedge clk);
    model_step(0, 0, 0, 0, 0);

    // 20 interlock cycles: 4-bit counter saturates, 32-bit keeps counting
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    intrlock_bubble = 0;
    #1;
    chk("sat_stall_w4", 64'(stall_cnt4), 64'(15));
    chk("sat_stall_w32", 64'(stall_cnt), 64'(20));
    @(posedge clk);
    model_step(0, 0, 0, 0, 0);

    // rst asserted mid-MWAIT and mid-FLUSH
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 79) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 intrlock_bubble  input  1  load-use interlock request from decode.
REQ-005 ex_branch_flush  input  1  branch mispredict flush from execute.
REQ-006 dmem_busy  input  1  data memory not ready; the whole pipe must freeze.
REQ-007 halt_req  input  1  ebreak/ecall reached writeback.
REQ-008 pc_en  output  1  fetch PC register update enable.
REQ-009 ifid_en  output  1  IF/ID pipe register enable.
REQ-010 idex_en, exma_en, mawb_en  output  1 each  downstream pipe register enables.
REQ-011 if_kill  output  1  replace the IF/ID payload with BUBBLE.
REQ-012 id_kill  output  1  replace the ID/EX payload with BUBBLE.
REQ-013 halted  output  1  core halted (sticky).
REQ-014 stall_cnt  output  CNT_W  count of cycles with pc_en=0 outside HALT.
REQ-015 flush_cnt  output  CNT_W  count of accepted branch flushes.

Function
REQ-016 The FSM SHALL have states RUN, FLUSH, MWAIT and HALT, with RUN entered after reset.
- Per-cycle priority: halt_req > dmem_busy > ex_branch_flush > intrlock_bubble.
REQ-017 In RUN with no request, all five enables SHALL be 1 and both kills SHALL be 0.
REQ-018 RUN with intrlock_bubble only:
- pc_en=0, ifid_en=0, id_kill=1; all other enables 1.
- State stays RUN; the response is combinational, with no added latency.
REQ-019 RUN with ex_branch_flush (no dmem_busy/halt_req):
- Same cycle: if_kill=1, id_kill=1, all enables 1; intrlock_bubble ignored.
- flush_cnt +1; next state FLUSH.
REQ-020 FLUSH lasts exactly one cycle: if_kill=1 (stale fetch from 1-cycle imem latency), id_kill=0, all enables 1, then RUN.
- A new ex_branch_flush in FLUSH is honoured as in REQ-019 and the state stays FLUSH.
REQ-021 dmem_busy in RUN or FLUSH:
- All enables 0 and kills 0 in that same cycle; next state MWAIT.
- A FLUSH interrupted by dmem_busy does not resume.
REQ-022 MWAIT:
- All enables 0, kills 0.
- ex_branch_flush and intrlock_bubble ignored, since EX is frozen and they re-present on release.
- Stay while dmem_busy=1; the first cycle with dmem_busy=0 behaves as RUN (REQ-017..019) and the state returns to RUN.
REQ-023 halt_req in any state:
- All enables 0, kills 0 in that cycle; next state HALT.
- HALT is left only by rst; halted=1 in HALT, 0 elsewhere.
REQ-024 stall_cnt SHALL increment every non-HALT cycle with pc_en=0 and saturate at all-ones.
REQ-025 flush_cnt SHALL saturate at all-ones.
REQ-026 No output SHALL be X after the first reset cycle, and outputs SHALL depend only on the current state and current inputs.

Reset
REQ-027 While rst=1:
- State RUN, counters 0, halted 0.
- All enables 0 and kills 0, overriding the FSM outputs.
REQ-028 rst asserted mid-MWAIT, FLUSH or HALT SHALL return the block to RUN with cleared counters on the next edge.
- Normal REQ-017 outputs resume the cycle after rst falls.

Structure
REQ-029 The state enum pipe_ctrl_st_t (RUN, FLUSH, MWAIT, HALT) SHALL live in the shared utils_top package next to the opcode and BUBBLE constants.
REQ-030 The saturating counter SHALL be one sub-module, pipe_ctrl_satcnt (parameter W; ports inc, clr, cnt), instantiated twice.
REQ-031 All other logic (next-state and output decode) SHALL be flat in pipe_ctrl.

Verification
REQ-032 Reset, then 10 idle cycles -> all enables 1, kills 0, stall_cnt=0, flush_cnt=0, halted=0.
REQ-033 intrlock_bubble=1 for 1 cycle -> pc_en=0, ifid_en=0, id_kill=1 that cycle; stall_cnt=1; then back to all-enable.
REQ-034 ex_branch_flush=1 and intrlock_bubble=1 together -> cycle N: if_kill=1, id_kill=1, pc_en=1; cycle N+1: if_kill=1 only; flush_cnt=1; stall_cnt=0.
REQ-035 dmem_busy=1 for 4 cycles with ex_branch_flush=1 throughout, released at cycle 5:
- Cycles 1-4: all enables 0.
- Cycle 5: flush accepted.
- Result: stall_cnt=4, flush_cnt=1.
REQ-036 halt_req pulse during MWAIT -> HALT next cycle, halted=1 for 20+ cycles despite other inputs; rst pulse -> RUN, counters 0.
REQ-037 With CNT_W=4, 20 interlock cycles -> stall_cnt saturates at 15.
